// File: rtl/ex_unit_pkg.sv
// ex_unit_pkg -- shared definitions for the execute stage.
// Holds the bus widths, enable levels, alusel/aluop code values used by decode
// and execute, the execute FSM state type, and the shift helper functions
// shared by ex_unit and ex_shift_iter.
package ex_unit_pkg;

    localparam int unsigned REG_W      = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [REG_W-1:0]      reg_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    // Result class (alusel)
    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

    // Operation codes (aluop)
    localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [7:0] EXE_ANDI_OP = 8'b0101_1001;
    localparam logic [7:0] EXE_ORI_OP  = 8'b0101_1010;
    localparam logic [7:0] EXE_XORI_OP = 8'b0101_1011;
    localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [7:0] EXE_SLLV_OP = 8'b0000_0100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [7:0] EXE_SRLV_OP = 8'b0000_0110;
    localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [7:0] EXE_SRAV_OP = 8'b0000_0111;

    typedef enum logic [1:0] {
        SH_NONE,
        SH_LL,
        SH_RL,
        SH_RA
    } shift_kind_t;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } ex_state_t;

    // Map an aluop to its shift direction; SH_NONE for anything that is not a shift.
    function automatic shift_kind_t decode_shift(input logic [7:0] op);
        shift_kind_t kind;
        case (op)
            EXE_SLL_OP, EXE_SLLV_OP: kind = SH_LL;
            EXE_SRL_OP, EXE_SRLV_OP: kind = SH_RL;
            EXE_SRA_OP, EXE_SRAV_OP: kind = SH_RA;
            default:                 kind = SH_NONE;
        endcase
        return kind;
    endfunction

    // Shift value by amt in the given direction; arithmetic right shifts fill
    // with the supplied sign bit rather than value[31], so a partially shifted
    // accumulator keeps the original operand's sign.
    function automatic reg_t shift_by(input reg_t value, input shift_kind_t kind,
                                      input logic sign, input logic [4:0] amt);
        logic signed [REG_W:0] ext;
        logic signed [REG_W:0] sra;
        reg_t                  res;
        ext = {sign, value};
        sra = ext >>> amt;
        case (kind)
            SH_LL:   res = value << amt;
            SH_RL:   res = value >> amt;
            SH_RA:   res = sra[REG_W-1:0];
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ex_shift_iter.sv
// ex_shift_iter -- iterative shifter datapath for long shifts.
// Holds the partially shifted accumulator, the remaining shift count and the
// original sign bit. A load applies the first SHIFT_STEP bits; each advance
// applies another SHIFT_STEP. The final (<= SHIFT_STEP) portion is applied
// combinationally on the result output once done is high.
// Ports:
//   clk, rst      clock, synchronous active-high reset (clears acc/cnt)
//   load          start a new long shift from value/kind/sa
//   advance       apply one more full SHIFT_STEP to the accumulator
//   kind, value   shift direction and operand to shift (used on load)
//   sa            total shift amount (used on load)
//   result        accumulator shifted by the remaining count
//   done          remaining count fits in the final cycle
module ex_shift_iter
    import ex_unit_pkg::*;
#(
    parameter int unsigned SHIFT_STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        advance,
    input  shift_kind_t kind,
    input  reg_t        value,
    input  logic [4:0]  sa,
    output reg_t        result,
    output logic        done
);

    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    reg_t        acc;
    logic [4:0]  cnt;
    logic        sign;
    shift_kind_t cur_kind;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            sign     <= 1'b0;
            cur_kind <= SH_NONE;
        end else if (load) begin
            acc      <= shift_by(value, kind, value[REG_W-1], STEP);
            cnt      <= sa - STEP;
            sign     <= value[REG_W-1];
            cur_kind <= kind;
        end else if (advance) begin
            acc <= shift_by(acc, cur_kind, sign, STEP);
            cnt <= cnt - STEP;
        end
    end

    assign done   = (cnt <= STEP);
    assign result = shift_by(acc, cur_kind, sign, cnt);

endmodule

// File: rtl/ex_unit.sv
// ex_unit -- execute stage: logic ops in one cycle, shifts iterated at up to
// SHIFT_STEP bits per cycle with a stall request back to the front end.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   valid_i                        decoded operation present
//   aluop_i, alusel_i              operation code and result class
//   reg1_i, reg2_i                 operands (reg1_i[4:0] is the shift amount)
//   wd_i, wreg_i                   destination address and write enable
//   stallreq_o                     freeze PC, IF/ID and ID/EX
//   ex_wreg_o, ex_wd_o, ex_wdata_o combinational forwarding bus to decode
//   mem_wreg_o, mem_wd_o, mem_wdata_o  registered EX/MEM outputs
module ex_unit
    import ex_unit_pkg::*;
#(
    parameter int unsigned SHIFT_STEP = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    input  logic [7:0]            aluop_i,
    input  logic [2:0]            alusel_i,
    input  logic [REG_W-1:0]      reg1_i,
    input  logic [REG_W-1:0]      reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    output logic                  stallreq_o,
    output logic                  ex_wreg_o,
    output logic [REG_ADDR_W-1:0] ex_wd_o,
    output logic [REG_W-1:0]      ex_wdata_o,
    output logic                  mem_wreg_o,
    output logic [REG_ADDR_W-1:0] mem_wd_o,
    output logic [REG_W-1:0]      mem_wdata_o
);

    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    ex_state_t   state;
    reg_addr_t   held_wd;
    logic        held_wreg;

    reg_t        logic_res;
    shift_kind_t kind;
    logic [4:0]  sa;
    logic        long_shift;
    logic        start;
    logic        advance;
    reg_t        iter_result;
    logic        iter_done;

    assign sa         = reg1_i[4:0];
    assign kind       = (alusel_i == EXE_RES_SHIFT) ? decode_shift(aluop_i) : SH_NONE;
    assign long_shift = (kind != SH_NONE) && (sa > STEP);

    always_comb begin
        logic_res = '0;
        if (alusel_i == EXE_RES_LOGIC) begin
            case (aluop_i)
                EXE_OR_OP,  EXE_ORI_OP:  logic_res = reg1_i | reg2_i;
                EXE_AND_OP, EXE_ANDI_OP: logic_res = reg1_i & reg2_i;
                EXE_XOR_OP, EXE_XORI_OP: logic_res = reg1_i ^ reg2_i;
                EXE_NOR_OP:              logic_res = ~(reg1_i | reg2_i);
                default:                 logic_res = '0;
            endcase
        end
    end

    // Completion and stall decode; everything is forced quiet while in reset.
    always_comb begin
        stallreq_o = 1'b0;
        ex_wreg_o  = WRITE_DISABLE;
        ex_wd_o    = '0;
        ex_wdata_o = '0;
        start      = 1'b0;
        advance    = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    if (valid_i) begin
                        if (long_shift) begin
                            stallreq_o = 1'b1;
                            start      = 1'b1;
                        end else begin
                            ex_wreg_o  = wreg_i;
                            ex_wd_o    = wd_i;
                            ex_wdata_o = (kind != SH_NONE)
                                       ? shift_by(reg2_i, kind, reg2_i[REG_W-1], sa)
                                       : logic_res;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (iter_done) begin
                        ex_wreg_o  = held_wreg;
                        ex_wd_o    = held_wd;
                        ex_wdata_o = iter_result;
                    end else begin
                        stallreq_o = 1'b1;
                        advance    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    ex_shift_iter #(
        .SHIFT_STEP(SHIFT_STEP)
    ) u_shift_iter (
        .clk    (clk),
        .rst    (rst),
        .load   (start),
        .advance(advance),
        .kind   (kind),
        .value  (reg2_i),
        .sa     (sa),
        .result (iter_result),
        .done   (iter_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            held_wd   <= '0;
            held_wreg <= WRITE_DISABLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state     <= ST_SHIFT;
                        held_wd   <= wd_i;
                        held_wreg <= wreg_i;
                    end
                end
                ST_SHIFT: begin
                    if (iter_done) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ex_wreg_o is low on any non-completing cycle, so this register loads a
    // bubble on those edges without a separate condition.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wreg_o  <= WRITE_DISABLE;
            mem_wd_o    <= '0;
            mem_wdata_o <= '0;
        end else begin
            mem_wreg_o  <= ex_wreg_o;
            mem_wd_o    <= ex_wd_o;
            mem_wdata_o <= ex_wdata_o;
        end
    end

endmodule

// File: tb/tb_ex_unit.sv
// tb_ex_unit -- scoreboard bench for ex_unit with SHIFT_STEP = 4.
module tb_ex_unit;
    import ex_unit_pkg::*;

    localparam int unsigned STEP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        stallreq_o;
    logic        ex_wreg_o;
    logic [4:0]  ex_wd_o;
    logic [31:0] ex_wdata_o;
    logic        mem_wreg_o;
    logic [4:0]  mem_wd_o;
    logic [31:0] mem_wdata_o;

    ex_unit #(.SHIFT_STEP(STEP)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .aluop_i    (aluop_i),
        .alusel_i   (alusel_i),
        .reg1_i     (reg1_i),
        .reg2_i     (reg2_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .stallreq_o (stallreq_o),
        .ex_wreg_o  (ex_wreg_o),
        .ex_wd_o    (ex_wd_o),
        .ex_wdata_o (ex_wdata_o),
        .mem_wreg_o (mem_wreg_o),
        .mem_wd_o   (mem_wd_o),
        .mem_wdata_o(mem_wdata_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  wd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic is_shift(input logic [7:0] op, input logic [2:0] sel);
        return sel == EXE_RES_SHIFT &&
               (op == EXE_SLL_OP || op == EXE_SLLV_OP || op == EXE_SRL_OP ||
                op == EXE_SRLV_OP || op == EXE_SRA_OP || op == EXE_SRAV_OP);
    endfunction

    function automatic logic [31:0] model(input logic [7:0] op, input logic [2:0] sel,
                                          input logic [31:0] r1, input logic [31:0] r2);
        logic signed [31:0] s;
        logic [31:0]        r;
        r = 32'h0;
        if (sel == EXE_RES_LOGIC) begin
            if (op == EXE_OR_OP  || op == EXE_ORI_OP)  r = r1 | r2;
            if (op == EXE_AND_OP || op == EXE_ANDI_OP) r = r1 & r2;
            if (op == EXE_XOR_OP || op == EXE_XORI_OP) r = r1 ^ r2;
            if (op == EXE_NOR_OP)                      r = ~(r1 | r2);
        end else if (sel == EXE_RES_SHIFT) begin
            s = r2;
            if (op == EXE_SLL_OP || op == EXE_SLLV_OP) r = r2 << r1[4:0];
            if (op == EXE_SRL_OP || op == EXE_SRLV_OP) r = r2 >> r1[4:0];
            if (op == EXE_SRA_OP || op == EXE_SRAV_OP) begin
                s = s >>> r1[4:0];
                r = s;
            end
        end
        return r;
    endfunction

    // Mem-stage monitor: every write must match the next scoreboard entry.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (mem_wreg_o === 1'b1) begin
            if (sb.size() == 0) begin
                check("mem_wreg_unexpected", 32'(mem_wreg_o), 32'd0);
            end else begin
                e = sb.pop_front();
                check("mem_wd", 32'(mem_wd_o), 32'(e.wd));
                check("mem_wdata", mem_wdata_o, e.data);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the op has completed.
    task automatic do_op(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [4:0] wd, input logic wr);
        int unsigned total;
        int unsigned sa;
        logic [31:0] res;
        sa    = r1[4:0];
        total = 1;
        if (is_shift(op, sel)) total = (sa == 0) ? 1 : (sa + STEP - 1) / STEP;
        res = model(op, sel, r1, r2);
        valid_i = 1'b1; aluop_i = op; alusel_i = sel;
        reg1_i = r1; reg2_i = r2; wd_i = wd; wreg_i = wr;
        if (wr) sb.push_back('{wd: wd, data: res});
        for (int unsigned k = 0; k < total; k++) begin
            @(negedge clk);
            check("stallreq", 32'(stallreq_o), 32'(k + 1 < total));
            if (k + 1 == total) begin
                check("ex_wreg", 32'(ex_wreg_o), 32'(wr));
                if (wr) begin
                    check("ex_wd", 32'(ex_wd_o), 32'(wd));
                    check("ex_wdata", ex_wdata_o, res);
                end
            end else begin
                check("ex_wreg_midshift", 32'(ex_wreg_o), 32'd0);
            end
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
    endtask

    task automatic idle_cycle();
        valid_i = 1'b0; wreg_i = 1'b1; wd_i = 5'd7;
        @(negedge clk);
        check("idle_ex_wreg", 32'(ex_wreg_o), 32'd0);
        check("idle_stall", 32'(stallreq_o), 32'd0);
        @(posedge clk); #1;
        check("idle_mem_wreg", 32'(mem_wreg_o), 32'd0);
    endtask

    localparam int N_OPS = 16;
    logic [7:0] op_tab [N_OPS] = '{EXE_OR_OP, EXE_AND_OP, EXE_XOR_OP, EXE_NOR_OP,
                                   EXE_ORI_OP, EXE_ANDI_OP, EXE_XORI_OP, EXE_SLL_OP,
                                   EXE_SLLV_OP, EXE_SRL_OP, EXE_SRLV_OP, EXE_SRA_OP,
                                   EXE_SRAV_OP, EXE_NOP_OP, 8'hEE, EXE_SRA_OP};
    logic [2:0] sel_tab [N_OPS] = '{EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC,
                                   EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_LOGIC, EXE_RES_SHIFT,
                                   EXE_RES_SHIFT, EXE_RES_SHIFT, EXE_RES_SHIFT, EXE_RES_SHIFT,
                                   EXE_RES_SHIFT, EXE_RES_NOP, EXE_RES_LOGIC, EXE_RES_LOGIC};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; valid_i = 1'b0; aluop_i = '0; alusel_i = '0;
        reg1_i = '0; reg2_i = '0; wd_i = '0; wreg_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_wreg", 32'(mem_wreg_o), 32'd0);
        check("rst_mem_wd", 32'(mem_wd_o), 32'd0);
        check("rst_mem_wdata", mem_wdata_o, 32'd0);
        valid_i = 1'b1; wreg_i = 1'b1; alusel_i = EXE_RES_SHIFT; aluop_i = EXE_SLL_OP;
        reg1_i = 32'd31;
        @(negedge clk);
        check("rst_stall", 32'(stallreq_o), 32'd0);
        check("rst_ex_wreg", 32'(ex_wreg_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; valid_i = 1'b0;

        // Directed cases
        do_op(EXE_OR_OP,  EXE_RES_LOGIC, 32'h1234_0000, 32'h0000_FFFF, 5'd3, 1'b1);
        do_op(EXE_SLL_OP, EXE_RES_SHIFT, 32'd31, 32'h0000_0001, 5'd4, 1'b1);
        do_op(EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000, 5'd5, 1'b1);
        do_op(EXE_SRAV_OP, EXE_RES_SHIFT, 32'h25, 32'h8000_0000, 5'd6, 1'b1);
        do_op(EXE_SRL_OP, EXE_RES_SHIFT, 32'd0, 32'hDEAD_BEEF, 5'd7, 1'b1);
        do_op(EXE_NOR_OP, EXE_RES_LOGIC, 32'd0, 32'd0, 5'd8, 1'b1);
        do_op(EXE_SRA_OP, EXE_RES_SHIFT, 32'd8, 32'h9000_00F0, 5'd9, 1'b1);
        do_op(EXE_SRLV_OP, EXE_RES_SHIFT, 32'hFFFF_FFED, 32'hF0F0_1234, 5'd10, 1'b1);
        do_op(EXE_NOP_OP, EXE_RES_NOP, 32'h1111_1111, 32'h2222_2222, 5'd11, 1'b1);
        do_op(8'hEE, EXE_RES_LOGIC, 32'hAAAA_AAAA, 32'h5555_5555, 5'd12, 1'b1);
        do_op(EXE_SLLV_OP, EXE_RES_SHIFT, 32'd5, 32'h0000_0003, 5'd13, 1'b0);
        idle_cycle();
        idle_cycle();

        // Reset during the third cycle of a 31-bit shift: no write may follow.
        valid_i = 1'b1; aluop_i = EXE_SLL_OP; alusel_i = EXE_RES_SHIFT;
        reg1_i = 32'd31; reg2_i = 32'h1; wd_i = 5'd20; wreg_i = 1'b1;
        @(negedge clk); check("abort_stall_c1", 32'(stallreq_o), 32'd1);
        @(posedge clk); #1;
        @(negedge clk); check("abort_stall_c2", 32'(stallreq_o), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_stall_rst", 32'(stallreq_o), 32'd0);
        check("abort_ex_wreg", 32'(ex_wreg_o), 32'd0);
        @(posedge clk); #1;
        check("abort_mem_wreg", 32'(mem_wreg_o), 32'd0);
        rst = 1'b0; valid_i = 1'b0;
        repeat (3) idle_cycle();

        // Random back-to-back mix
        for (int i = 0; i < 40; i++) begin
            int unsigned idx;
            idx = $urandom_range(N_OPS - 1, 0);
            do_op(op_tab[idx], sel_tab[idx], $urandom, $urandom,
                  5'($urandom_range(31, 0)), ($urandom_range(7, 0) != 0));
        end
        repeat (3) idle_cycle();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ex_unit.md
EX_UNIT -- requirements
Module: ex_unit

Interface
REQ-001 SHALL have parameter SHIFT_STEP, default 4, meaning max shift bits per cycle; legal values 1, 2, 4, 8.
REQ-002 SHALL have port clk, input, 1, clock: all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset is rst, synchronous, active-high.
REQ-004 SHALL have port valid_i, input, 1, decoded operation present this cycle.
REQ-005 SHALL have port aluop_i, input, 8, operation code from decode.
REQ-006 SHALL have port alusel_i, input, 3, result class: NOP, LOGIC or SHIFT.
REQ-007 SHALL have port reg1_i, input, 32, operand 1; bits [4:0] are the shift amount for shifts.
REQ-008 SHALL have port reg2_i, input, 32, operand 2; the shifted value for shifts.
REQ-009 SHALL have port wd_i, input, 5, destination register address.
REQ-010 SHALL have port wreg_i, input, 1, destination write enable.
REQ-011 SHALL have port stallreq_o, output, 1, request to freeze PC, IF/ID and ID/EX.
REQ-012 SHALL have ports ex_wreg_o (1), ex_wd_o (5) and ex_wdata_o (32), all outputs, forming the combinational forwarding bus back to decode.
REQ-013 SHALL have ports mem_wreg_o (1), mem_wd_o (5) and mem_wdata_o (32), all outputs, forming the registered EX/MEM stage outputs.

Function
REQ-014 SHALL compute LOGIC ops combinationally in 1 cycle: OR, AND, XOR, NOR; ORI, ANDI and XORI use the same functions as their register forms.
REQ-015 SHALL treat SLL/SLLV as logical left, SRL/SRLV as logical right, and SRA/SRAV as arithmetic right filling with original reg2_i[31]; sa = reg1_i[4:0].
REQ-016 SHALL implement an FSM with states IDLE and SHIFT.
REQ-017 SHALL, in IDLE with valid_i=1 and a shift op with sa<=SHIFT_STEP, complete in the same cycle without stall; sa=0 returns reg2_i unchanged.
REQ-018 SHALL, in IDLE with valid_i=1 and a shift op with sa>SHIFT_STEP, assert stallreq_o, load acc = reg2_i shifted by SHIFT_STEP and cnt = sa-SHIFT_STEP, capture wd_i/wreg_i/op, and enter SHIFT.
REQ-019 SHALL, in SHIFT, shift acc by min(cnt,SHIFT_STEP) each cycle; stallreq_o=1 while cnt>SHIFT_STEP; on the cycle cnt<=SHIFT_STEP, deassert stallreq_o, complete, and return to IDLE.
REQ-020 SHALL take ceil(max(sa,1)/SHIFT_STEP) cycles per shift, with stall cycles = total-1.
REQ-021 SHALL ignore ID/EX inputs during SHIFT; upstream holds them stable while stallreq_o=1.
REQ-022 SHALL drive ex_wreg_o/ex_wd_o/ex_wdata_o with the final result only on the completing cycle; otherwise ex_wreg_o=0.
REQ-023 SHALL register the completing cycle's result into mem_* at the next edge, giving 1-cycle latency from completion.
REQ-024 SHALL load mem_wreg_o=0 (bubble) on any edge with no completion, including valid_i=0 and mid-shift edges.
REQ-025 SHALL give result 0 for NOP or unknown alusel_i/aluop_i, with wreg passed through from wreg_i.
REQ-026 SHALL give a back-to-back op after a shift completion no added bubble.

Reset
REQ-027 SHALL, with rst=1 at an edge, set state=IDLE, cnt=0, acc=0 and all mem_* outputs to 0, and abort any in-flight shift with no write.
REQ-028 SHALL force stallreq_o=0 and ex_* outputs to 0 while rst=1.

Structure
REQ-029 SHALL take aluop/alusel codes, RegBus/RegAddrBus widths and Enable/Disable levels from the shared define.v; no local code values.
REQ-030 SHALL place the iterative shifter (acc, cnt, sign) in sub-module ex_shift_iter; FSM and EX/MEM register stay in ex_unit.

Verification
REQ-031 SHALL check: OR with reg1=0x12340000, reg2=0x0000FFFF, wd=3 -> no stall; next edge mem_wdata_o=0x1234FFFF, mem_wd_o=3, mem_wreg_o=1.
REQ-032 SHALL check: SLL with sa=31, reg2=0x00000001, SHIFT_STEP=4 -> stallreq_o high 7 cycles; 8th cycle ex_wdata_o=0x80000000; next edge mem_wdata_o=0x80000000.
REQ-033 SHALL check: SRA with sa=4, reg2=0x80000000 -> no stall, result 0xF8000000; SRAV with reg1=0x25 (sa=5), reg2=0x80000000 -> 1 stall cycle, result 0xFC000000.
REQ-034 SHALL check: SRL with sa=0, reg2=0xDEADBEEF -> result 0xDEADBEEF, no stall; NOR with 0,0 -> 0xFFFFFFFF.
REQ-035 SHALL check: rst pulsed on 3rd cycle of a sa=31 shift -> stallreq_o=0 and mem_wreg_o=0, and no write ever appears for that op.
REQ-036 SHALL check: valid_i=0 with wreg_i=1 -> mem_wreg_o=0 and ex_wreg_o=0.
